// File: rtl/spi_adc_responder.sv
// SPI responder that serves the latest sample word MSB-first on CIPO, emulating
// the sonar front-end ADC for loopback self-test and as a controller bench model.
module spi_adc_responder #(
    parameter int DATA_WIDTH  = 16,
    parameter int SYNC_STAGES = 0
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [DATA_WIDTH-1:0] sample_in,
    input  logic                  sample_valid_in,
    input  logic                  chip_sel_in,
    input  logic                  chip_clk_in,
    output logic                  chip_data_out,
    output logic                  busy_out,
    output logic                  frame_done_out,
    output logic                  frame_abort_out,
    output logic                  sample_stale_out,
    output logic [15:0]           frame_count_out
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    logic cs_s;
    logic sclk_s;

    generate
        if (SYNC_STAGES > 0) begin : g_sync
            logic [SYNC_STAGES-1:0] cs_sync_q;
            logic [SYNC_STAGES-1:0] cs_sync_d;
            logic [SYNC_STAGES-1:0] sclk_sync_q;
            logic [SYNC_STAGES-1:0] sclk_sync_d;

            always_comb begin
                cs_sync_d   = SYNC_STAGES'({cs_sync_q, chip_sel_in});
                sclk_sync_d = SYNC_STAGES'({sclk_sync_q, chip_clk_in});
            end

            always_ff @(posedge clk_in) begin
                if (rst_in) begin
                    cs_sync_q   <= '0;
                    sclk_sync_q <= '0;
                end else begin
                    cs_sync_q   <= cs_sync_d;
                    sclk_sync_q <= sclk_sync_d;
                end
            end

            assign cs_s   = cs_sync_q[SYNC_STAGES-1];
            assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
        end else begin : g_direct
            assign cs_s   = chip_sel_in;
            assign sclk_s = chip_clk_in;
        end
    endgenerate

    state_t                state_q, state_d;
    logic                  cs_q, cs_d;
    logic                  sclk_q, sclk_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  fresh_q, fresh_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic                  taken_q, taken_d;
    logic                  dout_q, dout_d;
    logic                  done_q, done_d;
    logic                  abort_q, abort_d;
    logic                  stale_q, stale_d;
    logic [15:0]           count_q, count_d;

    logic                  cs_fall;
    logic                  cs_rise;
    logic                  sclk_rise;
    logic                  sclk_fall;
    logic [DATA_WIDTH-1:0] load_word;

    // cs_q/sclk_q reset low, so a CS held low through reset never looks like a fall
    assign cs_fall   = cs_q & ~cs_s;
    assign cs_rise   = ~cs_q & cs_s;
    assign sclk_rise = ~sclk_q & sclk_s;
    assign sclk_fall = sclk_q & ~sclk_s;

    // A strobe coinciding with the CS fall is served directly (bypass)
    assign load_word = sample_valid_in ? sample_in : hold_q;

    always_comb begin
        state_d   = state_q;
        cs_d      = cs_s;
        sclk_d    = sclk_s;
        hold_d    = hold_q;
        fresh_d   = fresh_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        taken_d   = taken_q;
        dout_d    = dout_q;
        done_d    = 1'b0;
        abort_d   = 1'b0;
        stale_d   = stale_q;
        count_d   = count_q;

        if (sample_valid_in) begin
            hold_d  = sample_in;
            fresh_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                dout_d = 1'b0;
                if (cs_fall) begin
                    state_d   = ST_SHIFT;
                    shreg_d   = load_word;
                    dout_d    = load_word[DATA_WIDTH-1];
                    bit_cnt_d = '0;
                    taken_d   = 1'b0;
                    stale_d   = sample_valid_in ? 1'b0 : ~fresh_q;
                    fresh_d   = 1'b0;
                end
            end

            ST_SHIFT: begin
                // CS rise takes priority over any SCLK edge in the same cycle
                if (cs_rise) begin
                    state_d = ST_IDLE;
                    dout_d  = 1'b0;
                    abort_d = 1'b1;
                end else if (sclk_rise) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    taken_d   = 1'b1;
                    if (bit_cnt_q == LAST_CNT) begin
                        state_d = ST_DONE;
                        dout_d  = 1'b0;
                    end
                end else if (sclk_fall && taken_q) begin
                    // A fall with nothing taken yet is the idle-high SCLK case
                    shreg_d = shreg_q << 1;
                    dout_d  = shreg_q[DATA_WIDTH-2];
                    taken_d = 1'b0;
                end
            end

            ST_DONE: begin
                dout_d = 1'b0;
                if (cs_rise) begin
                    state_d = ST_IDLE;
                    if (bit_cnt_q == FULL_CNT) begin
                        done_d  = 1'b1;
                        count_d = count_q + 16'd1;
                    end else begin
                        abort_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                dout_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= ST_IDLE;
            cs_q      <= 1'b0;
            sclk_q    <= 1'b0;
            hold_q    <= '0;
            fresh_q   <= 1'b0;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            taken_q   <= 1'b0;
            dout_q    <= 1'b0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
            stale_q   <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            cs_q      <= cs_d;
            sclk_q    <= sclk_d;
            hold_q    <= hold_d;
            fresh_q   <= fresh_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            taken_q   <= taken_d;
            dout_q    <= dout_d;
            done_q    <= done_d;
            abort_q   <= abort_d;
            stale_q   <= stale_d;
            count_q   <= count_d;
        end
    end

    assign chip_data_out    = dout_q;
    assign busy_out         = (state_q != ST_IDLE);
    assign frame_done_out   = done_q;
    assign frame_abort_out  = abort_q;
    assign sample_stale_out = stale_q;
    assign frame_count_out  = count_q;

endmodule

// File: doc/spi_adc_responder.md
# spi_adc_responder

Synthesizable SPI responder that emulates the sonar front-end ADC on the far side of the `spi_con` read link. It holds the most recent sample word and shifts it out MSB-first on `chip_data_out` whenever a controller frames a transfer with `chip_sel_in` and `chip_clk_in`. It is used for on-FPGA loopback self-test of the receive chain, driving synthetic echo samples into `cipo0`/`cipo1`, and as the bench model for `spi_con`. All inputs are in the `clk_in` domain, or are synchronized by the block when `SYNC_STAGES > 0`.

## Interface
- `DATA_WIDTH`, 16: bits per frame, 2..32.
- `SYNC_STAGES`, 0: flops on `chip_sel_in`/`chip_clk_in` before edge detection, 0..3. 0 for same-domain loopback.
- `clk_in` input 1: system clock (100 MHz).
- `rst_in` input 1: reset. One clock; reset is synchronous and active-high.
- `sample_in` input DATA_WIDTH: next word to serve.
- `sample_valid_in` input 1: one-cycle strobe; writes `sample_in` into the holding register.
- `chip_sel_in` input 1: CS from controller, active-low.
- `chip_clk_in` input 1: SCLK from controller.
- `chip_data_out` output 1: CIPO, registered.
- `busy_out` output 1: high while a frame is in progress (states SHIFT and DONE).
- `frame_done_out` output 1: one-cycle pulse when CS rises after exactly DATA_WIDTH rising SCLK edges.
- `frame_abort_out` output 1: one-cycle pulse when CS rises after fewer than DATA_WIDTH rising edges.
- `sample_stale_out` output 1: high if the current or last frame loaded a word already served.
- `frame_count_out` output 16: count of completed frames. Wraps 0xFFFF -> 0.

## Operation
- Edge detection: the optionally synchronized `cs_s` and `sclk_s` are compared with registered copies `cs_q` and `sclk_q`. Reset values are `cs_q`=0 and `sclk_q`=0, so a CS held low through reset is not detected as a falling edge.
- Holding register `hold` is written on `sample_valid_in` in any state. Setting `fresh`=1 marks it unserved. Reset: `hold`=0, `fresh`=0.
- State IDLE:
  - `chip_data_out`=0.
  - CS fall (`cs_q`=1, `cs_s`=0) -> SHIFT. Load `shreg` from `hold`, drive `chip_data_out` from `hold[DATA_WIDTH-1]`, clear `bit_cnt` and `taken`.
  - `sample_stale_out` takes the value `~fresh`, then `fresh` is cleared.
  - If `sample_valid_in` coincides with the CS-fall cycle, the new `sample_in` is loaded (bypass), and `sample_stale_out`=0.
- State SHIFT:
  - SCLK rise: `bit_cnt`+1 and `taken`=1.
  - SCLK fall with `taken`=1: shift `shreg` left, drive the next bit, clear `taken`.
  - SCLK fall with `taken`=0 (idle-high SCLK, first fall) does not shift.
  - When `bit_cnt` reaches DATA_WIDTH -> DONE and `chip_data_out`=0.
- State DONE:
  - Further SCLK edges are ignored, with `chip_data_out` held at 0.
- CS rise in SHIFT or DONE -> IDLE:
  - `bit_cnt`==DATA_WIDTH: pulse `frame_done_out` and increment `frame_count_out`.
  - Otherwise: pulse `frame_abort_out` with no count change.
  - `chip_data_out`=0.
- Simultaneous CS rise and SCLK edge in one cycle: the CS rise wins, the SCLK edge is ignored, and the last edge does not count.
- `hold` writes during a frame never alter the word in flight.
- Reset mid-frame: immediately return to IDLE with all outputs at reset values and no done/abort pulse. The next frame starts only after CS goes high and then low again.

## Timing
- Reset values: `chip_data_out`=0, `busy_out`=0, `frame_done_out`=0, `frame_abort_out`=0, `sample_stale_out`=0, `frame_count_out`=0.
- Input-to-detect latency is SYNC_STAGES cycles. Detection-to-output is 1 cycle (registered).
- With SYNC_STAGES=0:
  - CS low sampled at cycle t: MSB valid on `chip_data_out` at t+1 and `busy_out`=1 at t+1.
  - SCLK fall sampled at t: next bit valid at t+1.
- Controller requirement: sample on the SCLK rising edge, with SCLK half-period ≥ SYNC_STAGES+2 cycles and ≥ SYNC_STAGES+2 cycles from CS fall to the first rising edge.
- `frame_done_out`/`frame_abort_out` assert at detect+1 and last exactly 1 cycle. `frame_count_out` updates in the same cycle.

## Test plan
- Basic frame: write `hold`=0xA5C3, then CS low and 16 SCLK periods with half-period 3 -> bits sampled on rise read 1010_0101_1100_0011, `frame_done_out` pulses once, and `frame_count_out`=1.
- Abort: CS high after 7 rising edges -> `frame_abort_out` pulses, count unchanged. The next full frame returns the same word with `sample_stale_out`=1.
- Mid-frame update: `sample_valid_in`=0x1234 during bit 5 of a 0xFFFF frame -> the frame reads 0xFFFF, and the next frame reads 0x1234 with `sample_stale_out`=0.
- Coincident load: `sample_valid_in`=0x8001 on the CS-fall detect cycle -> MSB=1 at t+1 and the frame reads 0x8001.
- Reset mid-frame: assert `rst_in` at bit 9 while CS stays low -> all outputs 0 and no pulse. SCLK toggling while CS is still low is ignored. A fresh CS high-then-low serves `hold`=0.
- Wrap and sync: with SYNC_STAGES=2, half-period 4, preset the count to 0xFFFF via 65535 frames (or force) -> the next done takes `frame_count_out` to 0. Data is correct with the 2-cycle added latency.
